// File: rtl/render_sched_pkg.sv
// Render scheduler types: sequencer states and slot index width.
package render_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT_DONE,
    SWAP
  } state_e;

  localparam int unsigned SLOT_IDX_W = $clog2(runner_pkg::RENDER_SLOTS);

endpackage

// File: rtl/runner_pkg.sv
// Shared game-runner types: render slot count and the sprite/position records
// that the game core publishes per slot.
package runner_pkg;

  localparam int unsigned RENDER_SLOTS = 32;

  // Sprite-sheet source rectangle; w == 0 or h == 0 marks an empty slot.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  w;
    logic [7:0]  h;
  } sprite_t;

  // Signed screen position of the sprite's top-left corner.
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } pos_t;

endpackage

// File: rtl/render_scheduler_if.sv
// Scheduler <-> blitter/display handshake bundle.
//   cmd_valid/cmd_ready : draw command handshake, payload cmd_sprite/cmd_pos/cmd_slot
//   blit_done           : blitter finished the accepted command (pulse)
//   swap_req/swap_ack   : framebuffer swap request and completion
// master = scheduler side, slave = blitter/display side.
interface render_scheduler_if
  import runner_pkg::*;
#(
  parameter int unsigned SLOTS = RENDER_SLOTS
);
  localparam int unsigned IDX_W = $clog2(SLOTS);

  logic             cmd_valid;
  logic             cmd_ready;
  sprite_t          cmd_sprite;
  pos_t             cmd_pos;
  logic [IDX_W-1:0] cmd_slot;
  logic             blit_done;
  logic             swap_req;
  logic             swap_ack;

  modport master (
    output cmd_valid, cmd_sprite, cmd_pos, cmd_slot, swap_req,
    input  cmd_ready, blit_done, swap_ack
  );

  modport slave (
    input  cmd_valid, cmd_sprite, cmd_pos, cmd_slot, swap_req,
    output cmd_ready, blit_done, swap_ack
  );

endinterface

// File: rtl/render_scheduler.sv
// Frame-level sequencer: snapshots all render slots on frame_start_i, issues
// one draw command per non-empty slot in ascending order (painter's order),
// waits for each blit to finish, then requests a framebuffer swap.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame_start_i     : one-cycle frame pulse
//   sprite_i, pos_i   : live per-slot rectangle and position from the game core
//   bus (master)      : command / blit_done / swap handshake
//   busy_o            : sequencer not idle
//   overrun_count_o   : saturating count of frame pulses dropped while busy
module render_scheduler
  import runner_pkg::*;
  import render_sched_pkg::*;
#(
  parameter int unsigned SLOTS = RENDER_SLOTS,
  parameter int unsigned OVR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start_i,
  input  sprite_t                sprite_i [SLOTS],
  input  pos_t                   pos_i    [SLOTS],
  render_scheduler_if.master     bus,
  output logic                   busy_o,
  output logic [OVR_W-1:0]       overrun_count_o
);

  localparam int unsigned    IDX_W     = $clog2(SLOTS);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic             cmd_valid_q, cmd_valid_d;
  sprite_t          cmd_sprite_q, cmd_sprite_d;
  pos_t             cmd_pos_q, cmd_pos_d;
  logic [IDX_W-1:0] cmd_slot_q, cmd_slot_d;
  logic             swap_req_q, swap_req_d;
  logic             busy_q, busy_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  sprite_t snap_sprite_q [SLOTS];
  pos_t    snap_pos_q    [SLOTS];

  logic    capture_c;
  sprite_t cur_sprite_c;
  pos_t    cur_pos_c;

  // Slot currently under evaluation, always read from the frozen snapshot.
  assign cur_sprite_c = snap_sprite_q[slot_q];
  assign cur_pos_c    = snap_pos_q[slot_q];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_sprite_d = cmd_sprite_q;
    cmd_pos_d    = cmd_pos_q;
    cmd_slot_d   = cmd_slot_q;
    swap_req_d   = swap_req_q;
    ovr_d        = ovr_q;
    capture_c    = 1'b0;

    // A frame pulse while busy is dropped, only counted.
    if (frame_start_i && (state_q != IDLE) && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          capture_c = 1'b1;
          slot_d    = '0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if ((cur_sprite_c.w == '0) || (cur_sprite_c.h == '0)) begin
          if (slot_q == LAST_SLOT) begin
            swap_req_d = 1'b1;
            state_d    = SWAP;
          end else begin
            slot_d = slot_q + IDX_W'(1);
          end
        end else begin
          cmd_valid_d  = 1'b1;
          cmd_sprite_d = cur_sprite_c;
          cmd_pos_d    = cur_pos_c;
          cmd_slot_d   = slot_q;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (bus.blit_done) begin
          if (slot_q == LAST_SLOT) begin
            swap_req_d = 1'b1;
            state_d    = SWAP;
          end else begin
            slot_d  = slot_q + IDX_W'(1);
            state_d = SCAN;
          end
        end
      end

      SWAP: begin
        if (bus.swap_ack) begin
          swap_req_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        cmd_valid_d = 1'b0;
        swap_req_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_sprite_q <= '0;
      cmd_pos_q    <= '0;
      cmd_slot_q   <= '0;
      swap_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_sprite_q <= cmd_sprite_d;
      cmd_pos_q    <= cmd_pos_d;
      cmd_slot_q   <= cmd_slot_d;
      swap_req_q   <= swap_req_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
    end
  end

  // Frame snapshot: written only in the IDLE capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        snap_sprite_q[i] <= '0;
        snap_pos_q[i]    <= '0;
      end
    end else if (capture_c) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        snap_sprite_q[i] <= sprite_i[i];
        snap_pos_q[i]    <= pos_i[i];
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_sprite  = cmd_sprite_q;
  assign bus.cmd_pos     = cmd_pos_q;
  assign bus.cmd_slot    = cmd_slot_q;
  assign bus.swap_req    = swap_req_q;
  assign busy_o          = busy_q;
  assign overrun_count_o = ovr_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler: a scripted control table, directed
// frames for the corner cases, and randomized frames against a frame-level model
// that derives the command list and handshake cycles from the slot contents.
module tb_render_scheduler;
  import runner_pkg::*;

  localparam int unsigned NS    = RENDER_SLOTS;
  localparam int unsigned IDX_W = $clog2(NS);

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    frame_start = 1'b0;
  sprite_t sprite_v [NS];
  pos_t    pos_v    [NS];
  logic    busy;
  logic [7:0] ovr;

  render_scheduler_if #(.SLOTS(NS)) bus ();

  render_scheduler #(.SLOTS(NS), .OVR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start_i   (frame_start),
    .sprite_i        (sprite_v),
    .pos_i           (pos_v),
    .bus             (bus),
    .busy_o          (busy),
    .overrun_count_o (ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_model = 0;

  // Frame content as the game core presents it at frame_start, plus blitter behaviour.
  sprite_t sp [NS];
  pos_t    ps [NS];
  int      stall [NS];
  int      lat [NS];

  typedef struct {
    logic rst;
    logic fs;
    logic ack;
    logic bd;
    int   reps;
    logic busy;
    logic valid;
    logic swap;
    logic [7:0] ovr;
  } vec_t;
  vec_t tbl [15];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < int'(NS); i++) begin
      sp[i] = '0;
      ps[i] = '0;
      stall[i] = 0;
      lat[i] = 1;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < int'(NS); i++) begin
      sp[i].x = 12'($urandom);
      sp[i].y = 12'($urandom);
      sp[i].w = 8'($urandom_range(1, 255));
      sp[i].h = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 3))
        0: sp[i].w = 8'd0;
        1: sp[i].h = 8'd0;
        default: ;
      endcase
      ps[i].x = 16'($urandom);
      ps[i].y = 16'($urandom);
      stall[i] = int'($urandom_range(0, 3));
      lat[i] = int'($urandom_range(1, 4));
    end
  endtask

  // Runs one frame from IDLE. Expected commands and handshake cycles come from
  // the slot contents: each slot costs one evaluation cycle; a non-empty one
  // shows cmd_valid the next cycle, is accepted after its stall, and the next
  // slot is evaluated the cycle after its blit_done.
  task automatic run_frame(input string name, input int ovr_pulses);
    int n, t, acc, done_at, seen, left, cur;
    bit finished;
    int exp_slot [$];
    int exp_acc [$];
    int exp_swap;

    for (int i = 0; i < int'(NS); i++) begin
      sprite_v[i] = sp[i];
      pos_v[i] = ps[i];
    end
    frame_start = 1'b1;
    n = cyc;
    tick();
    frame_start = 1'b0;

    t = n + 1;
    for (int i = 0; i < int'(NS); i++) begin
      if (sp[i].w == 8'd0 || sp[i].h == 8'd0) begin
        t = t + 1;
      end else begin
        acc = t + 1 + stall[i];
        exp_slot.push_back(i);
        exp_acc.push_back(acc);
        t = acc + lat[i] + 1;
      end
    end
    exp_swap = t;

    // Game core moves on; the frame being drawn must not change.
    for (int i = 0; i < int'(NS); i++) begin
      sprite_v[i].x = sp[i].x + 12'd88;
      sprite_v[i].w = 8'($urandom);
      pos_v[i] = pos_t'($urandom);
    end

    chk({name, ":busy_after_start"}, 80'(busy), 80'(1));

    done_at = -1;
    seen = 0;
    left = ovr_pulses;
    finished = 1'b0;
    for (int k = 0; k < 5000 && !finished; k++) begin
      bus.cmd_ready = 1'b0;
      bus.swap_ack = 1'b0;
      bus.blit_done = (cyc == done_at);
      frame_start = 1'b0;
      if (bus.cmd_valid) begin
        if (exp_slot.size() == 0) begin
          chk({name, ":unexpected_cmd_slot"}, 80'(bus.cmd_slot), 80'('1));
        end else begin
          cur = exp_slot[0];
          chk({name, ":cmd_payload"}, 80'({bus.cmd_slot, bus.cmd_sprite, bus.cmd_pos}),
              80'({IDX_W'(cur), sp[cur], ps[cur]}));
          if (seen == stall[cur]) begin
            bus.cmd_ready = 1'b1;
            chk({name, ":accept_cycle"}, 80'(cyc), 80'(exp_acc[0]));
            done_at = cyc + lat[cur];
            seen = 0;
            void'(exp_slot.pop_front());
            void'(exp_acc.pop_front());
          end else begin
            seen++;
            if (left > 0) begin
              frame_start = 1'b1;
              left--;
              if (ovr_model < 255) ovr_model++;
            end
          end
        end
      end
      if (bus.swap_req) begin
        chk({name, ":swap_cycle"}, 80'(cyc), 80'(exp_swap));
        chk({name, ":cmds_left_at_swap"}, 80'(exp_slot.size()), 80'(0));
        bus.swap_ack = 1'b1;
        tick();
        bus.swap_ack = 1'b0;
        bus.blit_done = 1'b0;
        chk({name, ":busy_after_ack"}, 80'(busy), 80'(0));
        chk({name, ":swap_after_ack"}, 80'(bus.swap_req), 80'(0));
        chk({name, ":overrun"}, 80'(ovr), 80'(ovr_model));
        finished = 1'b1;
      end else begin
        tick();
      end
    end
    bus.cmd_ready = 1'b0;
    bus.blit_done = 1'b0;
    frame_start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s:timeout no swap_req, busy=%0d expected swap at %0d", name, busy, exp_swap);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int wait_n;
    bus.cmd_ready = 1'b0;
    bus.blit_done = 1'b0;
    bus.swap_ack = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      sprite_v[i] = '0;
      pos_v[i] = '0;
    end

    // All-empty frames driven cycle by cycle: {rst, fs, ack, bd, reps, busy, valid, swap, ovr}.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 31, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 29, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 8'd0};

    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        rst = tbl[r].rst;
        frame_start = tbl[r].fs;
        bus.swap_ack = tbl[r].ack;
        bus.blit_done = tbl[r].bd;
        tick();
        chk($sformatf("tbl%0d:busy", r), 80'(busy), 80'(tbl[r].busy));
        chk($sformatf("tbl%0d:cmd_valid", r), 80'(bus.cmd_valid), 80'(tbl[r].valid));
        chk($sformatf("tbl%0d:swap_req", r), 80'(bus.swap_req), 80'(tbl[r].swap));
        chk($sformatf("tbl%0d:overrun", r), 80'(ovr), 80'(tbl[r].ovr));
      end
    end
    rst = 1'b0;
    frame_start = 1'b0;
    bus.swap_ack = 1'b0;
    bus.blit_done = 1'b0;
    ovr_model = 0;
    chk("reset:cmd_payload", 80'({bus.cmd_slot, bus.cmd_sprite, bus.cmd_pos}), 80'(0));

    // Slots 7 and 29, ready tied high, blit_done 3 cycles after acceptance.
    clear_frame();
    sp[7] = '{x: 12'd100, y: 12'd200, w: 8'd16, h: 8'd24};
    ps[7] = '{x: -16'sd5, y: 16'sd40};
    sp[29] = '{x: 12'd1678, y: 12'd300, w: 8'd32, h: 8'd32};
    ps[29] = '{x: 16'sd640, y: -16'sd20};
    lat[7] = 3;
    lat[29] = 3;
    run_frame("slots7_29", 0);

    // First and last slot occupied, zero-height slot in between is skipped.
    clear_frame();
    sp[0] = '{x: 12'd1, y: 12'd2, w: 8'd3, h: 8'd4};
    sp[15] = '{x: 12'd9, y: 12'd9, w: 8'd9, h: 8'd0};
    sp[31] = '{x: 12'd4095, y: 12'd4095, w: 8'd255, h: 8'd255};
    ps[31] = '{x: -16'sd32768, y: 16'sd32767};
    run_frame("slots0_31", 0);

    // Slot 13 held off for 20 cycles with three dropped frame pulses.
    clear_frame();
    sp[13] = '{x: 12'd77, y: 12'd88, w: 8'd8, h: 8'd8};
    ps[13] = '{x: 16'sd123, y: -16'sd456};
    stall[13] = 20;
    lat[13] = 2;
    run_frame("stall13", 3);
    chk("stall13:overrun_is_3", 80'(ovr), 80'(3));

    for (int f = 0; f < 8; f++) begin
      random_frame();
      run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 2)));
    end

    // Long stall with more pulses than the counter can hold.
    clear_frame();
    sp[5] = '{x: 12'd5, y: 12'd5, w: 8'd5, h: 8'd5};
    stall[5] = 300;
    run_frame("saturate", 300);
    chk("saturate:overrun_is_255", 80'(ovr), 80'(255));

    // Reset while waiting for blit_done abandons the frame.
    clear_frame();
    sp[7] = '{x: 12'd10, y: 12'd20, w: 8'd30, h: 8'd40};
    for (int i = 0; i < int'(NS); i++) begin
      sprite_v[i] = sp[i];
      pos_v[i] = ps[i];
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_n = 0;
    while (!bus.cmd_valid && wait_n < 100) begin
      tick();
      wait_n++;
    end
    chk("rst_wait:cmd_valid_seen", 80'(bus.cmd_valid), 80'(1));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk("rst_wait:in_wait_busy", 80'(busy), 80'(1));
    chk("rst_wait:in_wait_valid", 80'(bus.cmd_valid), 80'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ovr_model = 0;
    chk("rst_wait:busy", 80'(busy), 80'(0));
    chk("rst_wait:cmd_valid", 80'(bus.cmd_valid), 80'(0));
    chk("rst_wait:swap_req", 80'(bus.swap_req), 80'(0));
    chk("rst_wait:overrun", 80'(ovr), 80'(0));
    bus.blit_done = 1'b1;
    tick();
    bus.blit_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_wait:late_done_busy", 80'(busy), 80'(0));
      chk("rst_wait:late_done_valid", 80'(bus.cmd_valid), 80'(0));
      chk("rst_wait:late_done_swap", 80'(bus.swap_req), 80'(0));
    end

    random_frame();
    run_frame("after_reset", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
